// File: rtl/split_ram_loader.sv
// split_ram_loader: write sequencer for split_ram.
// Takes a valid/ready word stream and scatters it across NUM_RAMS banks in
// layer-interleaved order (word k -> bank k%NUM_RAMS, row k/NUM_RAMS).
// While a load is in progress it owns the shared RAM address. When idle it
// passes the consumer read address straight through.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, num_rows          begin a load of num_rows rows (sampled in IDLE)
//   in_data/in_valid/in_ready  input word stream
//   rd_addr                  consumer read address, forwarded when idle
//   busy, done               load in progress / 1-cycle completion pulse
//   ram_data_wr, ram_wren    registered write data and one-hot bank strobe
//   ram_addr                 shared RAM address (write row or rd_addr)
module split_ram_loader #(
   parameter int unsigned NUM_RAMS  = 8,
   parameter int unsigned RAM_DEPTH = 256,
   parameter int unsigned RAM_WIDTH = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [$clog2(RAM_DEPTH):0]     num_rows,
   input  logic [RAM_WIDTH-1:0]           in_data,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [$clog2(RAM_DEPTH)-1:0]   rd_addr,
   output logic                           busy,
   output logic                           done,
   output logic [RAM_WIDTH-1:0]           ram_data_wr,
   output logic [NUM_RAMS-1:0]            ram_wren,
   output logic [$clog2(RAM_DEPTH)-1:0]   ram_addr
);

   localparam int unsigned AW = $clog2(RAM_DEPTH);
   localparam int unsigned BW = (NUM_RAMS > 1) ? $clog2(NUM_RAMS) : 1;

   localparam logic [AW:0]          DEPTH_ROWS = (AW+1)'(RAM_DEPTH);
   localparam logic [AW:0]          ROW_ONE    = (AW+1)'(1);
   localparam logic [BW-1:0]        BANK_LAST  = BW'(NUM_RAMS - 1);
   localparam logic [BW-1:0]        BANK_ONE   = BW'(1);
   localparam logic [NUM_RAMS-1:0]  WREN_ONE   = NUM_RAMS'(1);

   typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

   state_t        state;
   logic [AW:0]   rows_q;
   // One bit wider than the row index so a full-depth load never wraps to row 0.
   logic [AW:0]   row_q;
   logic [BW-1:0] bank_q;
   logic [AW-1:0] addr_q;

   logic [AW:0]   rows_clamped_c;
   logic          handshake_c;
   logic          last_word_c;

   assign rows_clamped_c = (num_rows > DEPTH_ROWS) ? DEPTH_ROWS : num_rows;
   assign handshake_c    = in_valid & in_ready;
   assign last_word_c    = (bank_q == BANK_LAST) && ((row_q + ROW_ONE) == rows_q);

   // Idle read path is combinational so the consumer sees no added latency.
   assign ram_addr = busy ? addr_q : rd_addr;

   // Load sequencer with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         rows_q      <= '0;
         row_q       <= '0;
         bank_q      <= '0;
         addr_q      <= '0;
         in_ready    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         ram_wren    <= '0;
         ram_data_wr <= '0;
      end else begin
         done     <= 1'b0;
         ram_wren <= '0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  rows_q <= rows_clamped_c;
                  row_q  <= '0;
                  bank_q <= '0;
                  busy   <= 1'b1;
                  if (rows_clamped_c != '0) begin
                     state    <= LOAD;
                     in_ready <= 1'b1;
                  end else begin
                     state    <= FLUSH;
                  end
               end
            end
            LOAD: begin
               if (handshake_c) begin
                  ram_data_wr <= in_data;
                  ram_wren    <= WREN_ONE << bank_q;
                  addr_q      <= row_q[AW-1:0];
                  if (bank_q == BANK_LAST) begin
                     bank_q <= '0;
                     row_q  <= row_q + ROW_ONE;
                  end else begin
                     bank_q <= bank_q + BANK_ONE;
                  end
                  if (last_word_c) begin
                     state    <= FLUSH;
                     in_ready <= 1'b0;
                  end
               end
            end
            FLUSH: begin
               // Final write strobe is on the bus this cycle; close out the load.
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_split_ram_loader.sv
// Bench for split_ram_loader: behavioural word-index model compared every
// cycle, a bank/row mirror of the written RAM, and literal spot checks.
module tb_split_ram_loader;

   localparam int N  = 8;
   localparam int D  = 256;
   localparam int W  = 16;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW:0]   num_rows;
   logic [W-1:0]  in_data;
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] rd_addr;
   logic          busy;
   logic          done;
   logic [W-1:0]  ram_data_wr;
   logic [N-1:0]  ram_wren;
   logic [AW-1:0] ram_addr;

   split_ram_loader #(.NUM_RAMS(N), .RAM_DEPTH(D), .RAM_WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .rd_addr(rd_addr), .busy(busy), .done(done),
      .ram_data_wr(ram_data_wr), .ram_wren(ram_wren), .ram_addr(ram_addr)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: phase 0 idle, 1 loading, 2 final-write cycle.
   int            m_phase = 0;
   int            m_k = 0;
   int            m_total = 0;
   bit            model_live = 0;
   logic          exp_in_ready, exp_busy, exp_done;
   logic [N-1:0]  exp_wren;
   logic [W-1:0]  exp_data;
   logic [AW-1:0] exp_addr;

   always @(posedge clk) begin
      if (rst) begin
         model_live = 1;
         m_phase = 0; m_k = 0; m_total = 0;
         exp_in_ready = 0; exp_busy = 0; exp_done = 0;
         exp_wren = '0; exp_data = '0; exp_addr = '0;
      end else if (model_live) begin
         exp_done = 0;
         exp_wren = '0;
         case (m_phase)
            0: if (start) begin
               int rows;
               rows = (int'(num_rows) > D) ? D : int'(num_rows);
               m_total = rows * N;
               m_k = 0;
               m_phase = (rows != 0) ? 1 : 2;
            end
            1: if (in_valid) begin
               exp_data = in_data;
               exp_wren = N'(1) << (m_k % N);
               exp_addr = AW'(m_k / N);
               m_k++;
               if (m_k == m_total) m_phase = 2;
            end
            default: begin
               exp_done = 1;
               m_phase = 0;
            end
         endcase
         exp_in_ready = (m_phase == 1);
         exp_busy     = (m_phase != 0);
      end
   end

   // Written-RAM mirror and event counters, driven from the DUT's RAM port.
   logic [W-1:0] mem [N][D];
   int n_strobes = 0;
   int n_done = 0;
   int last_bank = -1;
   int last_addr = -1;

   always @(negedge clk) begin
      if (model_live && !rst) begin
         check("in_ready", 32'(in_ready), 32'(exp_in_ready));
         check("busy", 32'(busy), 32'(exp_busy));
         check("done", 32'(done), 32'(exp_done));
         check("ram_wren", 32'(ram_wren), 32'(exp_wren));
         check("ram_data_wr", 32'(ram_data_wr), 32'(exp_data));
         check("ram_addr", 32'(ram_addr), 32'(exp_busy ? exp_addr : rd_addr));
         if (ram_wren != '0) begin
            n_strobes++;
            for (int b = 0; b < N; b++)
               if (ram_wren[b]) begin
                  mem[b][ram_addr] = ram_data_wr;
                  last_bank = b;
               end
            last_addr = int'(ram_addr);
         end
         if (done === 1'b1) n_done++;
      end
   end

   task automatic clear_mem();
      for (int b = 0; b < N; b++)
         for (int r = 0; r < D; r++) mem[b][r] = '0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_start(input int rows);
      num_rows = (AW+1)'(rows);
      start = 1'b1;
      tick();
      start = 1'b0;
      num_rows = (AW+1)'($urandom_range(511));
   endtask

   // Offers words base+idx until nwords are accepted or limit cycles pass.
   task automatic stream(input int nwords, input int gap_pct, input int limit,
                         input int base, output int accepted);
      int idx = 0;
      logic v_s, r_s;
      for (int c = 0; c < limit && idx < nwords; c++) begin
         in_valid = ($urandom_range(99) >= gap_pct);
         in_data  = W'(base + idx);
         rd_addr  = AW'($urandom);
         v_s = in_valid;
         r_s = in_ready;
         tick();
         if (v_s && r_s) idx++;
      end
      in_valid = 1'b0;
      in_data  = W'($urandom);
      accepted = idx;
   endtask

   task automatic wait_done(input int limit, input string name);
      bit ok = 0;
      for (int c = 0; c < limit && !ok; c++) begin
         @(negedge clk);
         if (done === 1'b1) ok = 1;
      end
      tick();
      check(name, 32'(ok), 32'd1);
   endtask

   task automatic check_two_rows(input string name);
      for (int b = 0; b < N; b++) begin
         check(name, 32'(mem[b][0]), 32'h100 + 32'(b));
         check(name, 32'(mem[b][1]), 32'h108 + 32'(b));
      end
   endtask

   initial begin
      int acc, s0, d0;
      rst = 1'b1; start = 1'b0; num_rows = '0; in_data = '0;
      in_valid = 1'b0; rd_addr = '0;
      clear_mem();
      repeat (3) tick();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_wren", 32'(ram_wren), 32'd0);
      check("rst_data", 32'(ram_data_wr), 32'd0);
      rst = 1'b0;
      repeat (2) tick();

      // Two rows, back-to-back words.
      s0 = n_strobes;
      do_start(2);
      stream(16, 0, 40, 16'h100, acc);
      check("t1_accepted", 32'(acc), 32'd16);
      wait_done(10, "t1_done_seen");
      check_two_rows("t1_mem");
      check("t1_lane3_row1", 32'(mem[3][1]), 32'h10B);
      check("t1_strobes", 32'(n_strobes - s0), 32'd16);

      // Same load with ~40% valid gaps.
      clear_mem();
      s0 = n_strobes;
      do_start(2);
      stream(16, 40, 200, 16'h100, acc);
      check("t2_accepted", 32'(acc), 32'd16);
      wait_done(10, "t2_done_seen");
      check_two_rows("t2_mem");
      check("t2_strobes", 32'(n_strobes - s0), 32'd16);

      // Zero-row load: done exactly two cycles after start.
      s0 = n_strobes;
      in_valid = 1'b1;
      do_start(0);
      check("t3_done_early", 32'(done), 32'd0);
      tick();
      check("t3_done", 32'(done), 32'd1);
      check("t3_in_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      repeat (3) tick();
      check("t3_strobes", 32'(n_strobes - s0), 32'd0);

      // Oversized request clamps to full depth; extra words refused.
      s0 = n_strobes;
      do_start(300);
      stream(2100, 0, 2070, 0, acc);
      check("t4_accepted", 32'(acc), 32'd2048);
      check("t4_strobes", 32'(n_strobes - s0), 32'd2048);
      check("t4_last_bank", 32'(last_bank), 32'd7);
      check("t4_last_addr", 32'(last_addr), 32'd255);
      check("t4_in_ready", 32'(in_ready), 32'd0);
      check("t4_row255_b7", 32'(mem[7][255]), 32'(2047));

      // Start while busy is ignored.
      s0 = n_strobes; d0 = n_done;
      do_start(2);
      stream(3, 0, 10, 16'h100, acc);
      num_rows = 9'd5; start = 1'b1;
      tick();
      start = 1'b0;
      stream(13, 20, 100, 16'h100 + 4, acc);
      wait_done(10, "t5_done_seen");
      repeat (3) tick();
      check("t5_strobes", 32'(n_strobes - s0), 32'd16);
      check("t5_done_count", 32'(n_done - d0), 32'd1);

      // Reset mid-load abandons the load without a done pulse.
      do_start(4);
      stream(5, 0, 10, 16'h300, acc);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      d0 = n_done;
      rd_addr = 8'h5A;
      #1;
      check("t5_rst_busy", 32'(busy), 32'd0);
      check("t5_rst_wren", 32'(ram_wren), 32'd0);
      check("t5_rst_in_ready", 32'(in_ready), 32'd0);
      check("t5_rst_addr", 32'(ram_addr), 32'h5A);
      repeat (8) tick();
      check("t5_no_done", 32'(n_done - d0), 32'd0);

      // Idle sweep of the read address.
      for (int a = 0; a < D; a++) begin
         rd_addr = AW'(a);
         #1;
         check("t6_ram_addr", 32'(ram_addr), 32'(a));
         check("t6_wren", 32'(ram_wren), 32'd0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
